mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
// Serialises 1/2/4-byte transfers into consecutive byte accesses and returns assembled words.
// Raises per-requester stall requests so the pipeline control can freeze the stages.
// Sits between the IF/MEM stages and the RAM; MEM has priority over IF.
// PARAMETERS
// ADDR_W  32  address width of requests and RAM port
// DATA_W  32  request data width; fixed at 4 bytes
// PORTS
// clk          in   1       clock, all state updates on posedge
// rst          in   1       asynchronous reset, active-high
// if_req       in   1       IF fetch request; held high until if_done
// if_addr      in   ADDR_W  fetch byte address; always 4-byte read
// if_data      out  DATA_W  fetched word, valid while if_done=1
// if_done      out  1       one-cycle completion pulse for IF
// mem_req      in   1       MEM request; held high until mem_done
// mem_we       in   1       1=store, 0=load
// mem_len      in   2       00=1B, 01=2B, 10/11=4B
// mem_addr     in   ADDR_W  MEM byte address
// mem_wdata    in   DATA_W  store data, little-endian, byte0=[7:0]
// mem_rdata    out  DATA_W  load data, zero-extended, valid while mem_done=1
// mem_done     out  1       one-cycle completion pulse for MEM
// stallreq_if  out  1       if_req & ~if_done
// stallreq_mem out  1       mem_req & ~mem_done
// ram_addr     out  ADDR_W  RAM byte address
// ram_we       out  1       RAM write enable for the current cycle
// ram_dout     out  8       RAM write byte
// ram_din      in   8       RAM read byte; 1-cycle latency after ram_addr
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, if_data/mem_rdata=0, if_done/mem_done=0, ram_addr=0, ram_we=0, ram_dout=0.
// - States: IDLE, BUSY. Latched at acceptance: owner, base addr, N bytes, we, wdata.
// - Acceptance: only in IDLE with both done outputs low.
//   - mem_req wins over if_req.
//   - Accepted at the edge closing cycle 0 (first cycle req is seen); BUSY starts in cycle 1 with cnt=0.
// - ram_addr/ram_we/ram_dout are combinational from registered state.
//   - In IDLE, and in BUSY with cnt>=N: ram_we=0, ram_addr=0, ram_dout=0.
// - Write: BUSY cnt=0..N-1 drives ram_addr=base+cnt, ram_we=1, ram_dout=wdata byte cnt.
//   - N BUSY cycles, then IDLE with done=1 for one cycle.
// - Read: BUSY cnt=0..N-1 drives ram_addr=base+cnt, ram_we=0.
//   - At cnt=1..N, the edge captures ram_din into byte cnt-1; bytes >=N are 0.
//   - N+1 BUSY cycles, then IDLE with done=1 for one cycle; data reg holds until next capture.
// - Word read: done in cycle 6. Word write: done in cycle 5. Byte read: done in cycle 3.
// - Address arithmetic is modulo 2^ADDR_W; base+cnt wraps 0xFFFFFFFF -> 0x00000000.
// - Inputs are ignored while BUSY.
// - Requester dropping req mid-transfer: transfer still completes and done still pulses.
// - Done cycle blocks acceptance, so a held req is not re-served. Back-to-back requests: next BUSY cycle = done cycle + 2.
// - Reset mid-transfer: immediate return to IDLE; ram_we falls asynchronously; no done pulse; partial writes are not undone.
// TESTING
// - Reset with both reqs high -> all outputs 0; no RAM activity while rst=1.
// - IF word read at 0x1000, RAM bytes 13,05,00,00:
//   -> ram_addr 0x1000..0x1003 in cycles 1-4; if_done=1 in cycle 6; if_data=0x00000513.
// - if_req and MEM store word 0xDEADBEEF @0x2000 together in cycle 0:
//   -> ram_we with EF,BE,AD,DE in cycles 1-4; mem_done in cycle 5; IF BUSY from cycle 7; if_done in cycle 12.
// - MEM byte load @0x3, RAM=0x80 -> ram_addr 0x3 in cycle 1; mem_done in cycle 3; mem_rdata=0x00000080.
// - MEM halfword store 0xA5C3 @0xFFFFFFFF -> C3 @0xFFFFFFFF in cycle 1, A5 @0x00000000 in cycle 2.
// - rst pulsed in cycle 3 of a word store -> ram_we low immediately, no mem_done; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter that shares one byte-wide RAM port between
// instruction fetch and the MEM stage; MEM requests take priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              owner_mem;
  logic [ADDR_W-1:0] base;
  logic [2:0]        nbytes;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        cnt;

  logic              accept, accept_mem, accept_if;
  logic              last;
  logic [1:0]        lane;
  logic [DATA_W-1:0] rd_next;

  // The done cycle blocks acceptance so a still-held request is not served twice.
  assign accept     = (state == IDLE) && !if_done && !mem_done;
  assign accept_mem = accept && mem_req;
  assign accept_if  = accept && !mem_req && if_req;

  // Reads need one extra cycle because ram_din lags ram_addr by a cycle.
  assign last = (state == BUSY) && (we_q ? (cnt == nbytes - 3'd1) : (cnt == nbytes));

  assign stallreq_if  = if_req & ~if_done;
  assign stallreq_mem = mem_req & ~mem_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mem || accept_if) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port outputs, decoded from registered state only.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_dout = '0;
    if (state == BUSY && cnt < nbytes) begin
      ram_addr = base + ADDR_W'(cnt);
      ram_we   = we_q;
      if (we_q) ram_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
    end
  end

  // Read assembly: the first captured byte clears the upper lanes (zero-extension).
  assign lane = cnt[1:0] - 2'd1;

  always_comb begin
    rd_next = (cnt == 3'd1) ? '0 : (owner_mem ? mem_rdata : if_data);
    rd_next[{lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      owner_mem <= 1'b0;
      base      <= '0;
      nbytes    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (accept_mem || accept_if) begin
        owner_mem <= accept_mem;
        base      <= accept_mem ? mem_addr : if_addr;
        nbytes    <= !accept_mem ? 3'd4 : (mem_len == 2'b00) ? 3'd1 :
                     (mem_len == 2'b01) ? 3'd2 : 3'd4;
        we_q      <= accept_mem && mem_we;
        wdata_q   <= mem_wdata;
        cnt       <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 3'd1;
        if (!we_q && cnt != 3'd0) begin
          if (owner_mem) mem_rdata <= rd_next;
          else           if_data   <= rd_next;
        end
        if (last) begin
          if (owner_mem) mem_done <= 1'b1;
          else           if_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table against a
// read-only byte ROM model, plus hand sequences for reset and dropped requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [1:0]  mem_len;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic        if_done, mem_done, stallreq_if, stallreq_mem, ram_we;
  logic [7:0]  ram_dout, ram_din;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_0003: return 8'h80;
      32'hFFFF_FFFF: return 8'h7F;
      32'h0000_0000: return 8'h11;
      32'h0000_0001: return 8'h22;
      32'h0000_0002: return 8'h33;
      default:       return 8'h00;
    endcase
  endfunction

  // RAM read path with one cycle of latency.
  always @(posedge clk) ram_din <= rom(ram_addr);

  typedef struct {
    logic        if_req;
    logic        mem_req;
    logic [31:0] if_addr;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] e_addr;
    logic        e_we;
    logic [7:0]  e_dout;
    logic        e_if_done;
    logic        e_mem_done;
    logic [31:0] e_data;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] cur_if_addr, cur_mem_addr, cur_mem_wdata;
  logic        cur_mem_we;
  logic [1:0]  cur_mem_len;

  function automatic vec_t v(input logic ir, input logic mr, input logic [31:0] ea,
                             input logic ew, input logic [7:0] ed, input logic eid,
                             input logic emd, input logic [31:0] edata);
    vec_t r;
    r.if_req = ir;  r.mem_req = mr;  r.if_addr = cur_if_addr;
    r.mem_we = cur_mem_we;  r.mem_len = cur_mem_len;
    r.mem_addr = cur_mem_addr;  r.mem_wdata = cur_mem_wdata;
    r.e_addr = ea;  r.e_we = ew;  r.e_dout = ed;
    r.e_if_done = eid;  r.e_mem_done = emd;  r.e_data = edata;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram_idle(input string tag);
    check({tag, " ram_addr"}, ram_addr, 32'h0);
    check({tag, " ram_we"}, {31'b0, ram_we}, 32'h0);
    check({tag, " ram_dout"}, {24'b0, ram_dout}, 32'h0);
  endtask

  initial begin
    // Reset with both requests asserted: everything stays at zero.
    rst = 1'b1;
    if_req = 1'b1;  mem_req = 1'b1;  mem_we = 1'b1;  mem_len = 2'b10;
    if_addr = 32'h1000;  mem_addr = 32'h2000;  mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_ram_idle($sformatf("rst%0d", c));
      check($sformatf("rst%0d done", c), {30'b0, if_done, mem_done}, 32'h0);
      check($sformatf("rst%0d if_data", c), if_data, 32'h0);
      check($sformatf("rst%0d mem_rdata", c), mem_rdata, 32'h0);
    end
    next_cycle();
    if_req = 1'b0;  mem_req = 1'b0;
    rst = 1'b0;
    next_cycle();

    // A: IF word read at 0x1000.
    cur_if_addr = 32'h1000;  cur_mem_we = 1'b0;  cur_mem_len = 2'b00;
    cur_mem_addr = 32'h0;  cur_mem_wdata = 32'h0;
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1000, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1001, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1002, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1003, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 1, 0, 32'h0000_0513));
    vq.push_back(v(0, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    // B: IF read and MEM word store together; MEM goes first.
    cur_mem_we = 1'b1;  cur_mem_len = 2'b10;  cur_mem_addr = 32'h2000;  cur_mem_wdata = 32'hDEADBEEF;
    vq.push_back(v(1, 1, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 1, 32'h2000, 1, 8'hEF, 0, 0, 32'h0));
    vq.push_back(v(1, 1, 32'h2001, 1, 8'hBE, 0, 0, 32'h0));
    vq.push_back(v(1, 1, 32'h2002, 1, 8'hAD, 0, 0, 32'h0));
    vq.push_back(v(1, 1, 32'h2003, 1, 8'hDE, 0, 0, 32'h0));
    vq.push_back(v(1, 1, 32'h0,    0, 8'h00, 0, 1, 32'h0));
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1000, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1001, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1002, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h1003, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(1, 0, 32'h0,    0, 8'h00, 1, 0, 32'h0000_0513));
    vq.push_back(v(0, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    // C: MEM byte load at 0x3.
    cur_mem_we = 1'b0;  cur_mem_len = 2'b00;  cur_mem_addr = 32'h3;
    vq.push_back(v(0, 1, 32'h0, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h3, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0, 0, 8'h00, 0, 1, 32'h0000_0080));
    vq.push_back(v(0, 0, 32'h0, 0, 8'h00, 0, 0, 32'h0));
    // D: MEM halfword store wrapping past the top of the address space.
    cur_mem_we = 1'b1;  cur_mem_len = 2'b01;  cur_mem_addr = 32'hFFFF_FFFF;  cur_mem_wdata = 32'h1234_A5C3;
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'hFFFF_FFFF, 1, 8'hC3, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,         1, 8'hA5, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 1, 32'h0));
    vq.push_back(v(0, 0, 32'h0,         0, 8'h00, 0, 0, 32'h0));
    // E: MEM halfword load at 0x1000, upper bytes zero-extended.
    cur_mem_we = 1'b0;  cur_mem_len = 2'b01;  cur_mem_addr = 32'h1000;
    vq.push_back(v(0, 1, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h1000, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h1001, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,    0, 8'h00, 0, 1, 32'h0000_0513));
    vq.push_back(v(0, 0, 32'h0,    0, 8'h00, 0, 0, 32'h0));
    // F: MEM load with len=11 (word) that wraps the address.
    cur_mem_len = 2'b11;  cur_mem_addr = 32'hFFFF_FFFF;
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'hFFFF_FFFF, 0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h1,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h2,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 0, 32'h0));
    vq.push_back(v(0, 1, 32'h0,         0, 8'h00, 0, 1, 32'h3322_117F));
    vq.push_back(v(0, 0, 32'h0,         0, 8'h00, 0, 0, 32'h0));

    foreach (vq[i]) begin
      if_req = vq[i].if_req;  mem_req = vq[i].mem_req;  if_addr = vq[i].if_addr;
      mem_we = vq[i].mem_we;  mem_len = vq[i].mem_len;
      mem_addr = vq[i].mem_addr;  mem_wdata = vq[i].mem_wdata;
      @(negedge clk);
      check($sformatf("v%0d ram_addr", i), ram_addr, vq[i].e_addr);
      check($sformatf("v%0d ram_we", i), {31'b0, ram_we}, {31'b0, vq[i].e_we});
      check($sformatf("v%0d ram_dout", i), {24'b0, ram_dout}, {24'b0, vq[i].e_dout});
      check($sformatf("v%0d if_done", i), {31'b0, if_done}, {31'b0, vq[i].e_if_done});
      check($sformatf("v%0d mem_done", i), {31'b0, mem_done}, {31'b0, vq[i].e_mem_done});
      check($sformatf("v%0d stallreq_if", i), {31'b0, stallreq_if},
            {31'b0, vq[i].if_req & ~vq[i].e_if_done});
      check($sformatf("v%0d stallreq_mem", i), {31'b0, stallreq_mem},
            {31'b0, vq[i].mem_req & ~vq[i].e_mem_done});
      if (vq[i].e_if_done) check($sformatf("v%0d if_data", i), if_data, vq[i].e_data);
      if (vq[i].e_mem_done && !vq[i].mem_we)
        check($sformatf("v%0d mem_rdata", i), mem_rdata, vq[i].e_data);
      next_cycle();
    end

    // IF drops its request in cycle 2; the fetch still completes.
    if_req = 1'b1;  if_addr = 32'h1000;
    for (int c = 0; c <= 7; c++) begin
      if (c == 2) if_req = 1'b0;
      @(negedge clk);
      check($sformatf("drop c%0d if_done", c), {31'b0, if_done}, {31'b0, c == 6});
      if (c == 2) check("drop stallreq_if", {31'b0, stallreq_if}, 32'h0);
      if (c == 6) check("drop if_data", if_data, 32'h0000_0513);
      next_cycle();
    end

    // Reset in cycle 3 of a word store: ram_we falls at once, no done pulse.
    mem_req = 1'b1;  mem_we = 1'b1;  mem_len = 2'b10;
    mem_addr = 32'h2000;  mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) next_cycle();
    check("rstmid ram_we before", {31'b0, ram_we}, 32'h1);
    check("rstmid ram_addr before", ram_addr, 32'h2002);
    rst = 1'b1;
    mem_req = 1'b0;
    #1;
    check_ram_idle("rstmid async");
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rstmid c%0d mem_done", c), {31'b0, mem_done}, 32'h0);
      check($sformatf("rstmid c%0d ram_we", c), {31'b0, ram_we}, 32'h0);
      next_cycle();
    end

    // A fresh byte load after reset completes normally.
    mem_req = 1'b1;  mem_we = 1'b0;  mem_len = 2'b00;  mem_addr = 32'h3;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) mem_req = 1'b0;
      @(negedge clk);
      check($sformatf("post c%0d mem_done", c), {31'b0, mem_done}, {31'b0, c == 3});
      if (c == 1) check("post ram_addr", ram_addr, 32'h3);
      if (c == 3) check("post mem_rdata", mem_rdata, 32'h0000_0080);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
